// File: rtl/redmule_tcdm_splitter.sv
// Wide-to-narrow TCDM splitter for the RedMulE HCI data port.
// Fans one DW-bit transaction out to MP 32-bit lanes, tolerates lanes that
// grant in different cycles, buffers per-lane responses and reassembles them
// into one in-order wide response.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_i / gnt_o       wide request / wide grant (gnt_o combinational)
//   add_i, wen_i, be_i, data_i   wide request payload (wen_i=1 is a read)
//   r_data_o, r_valid_o wide response (no back-pressure)
//   lane_*_o / lane_*_i per-lane TCDM request and response signals
//   err_o               sticky protocol error (FIFO overflow / stray response)
module redmule_tcdm_splitter #(
  parameter int unsigned DW              = 288,
  parameter int unsigned MP              = DW / 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [31:0]      add_i,
  input  logic             wen_i,
  input  logic [DW/8-1:0]  be_i,
  input  logic [DW-1:0]    data_i,
  output logic [DW-1:0]    r_data_o,
  output logic             r_valid_o,
  output logic [MP-1:0]    lane_req_o,
  input  logic [MP-1:0]    lane_gnt_i,
  output logic [MP*32-1:0] lane_add_o,
  output logic [MP-1:0]    lane_wen_o,
  output logic [MP*4-1:0]  lane_be_o,
  output logic [MP*32-1:0] lane_data_o,
  input  logic [MP*32-1:0] lane_r_data_i,
  input  logic [MP-1:0]    lane_r_valid_i,
  output logic             err_o
);

  localparam int unsigned   CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned   PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  logic [MP-1:0] granted_q;
  logic [CW-1:0] out_q;
  logic          r_valid_q;
  logic [DW-1:0] r_data_q;
  logic          err_q;

  logic [31:0]   fifo_q [MP][MAX_OUTSTANDING];
  logic [PW-1:0] wptr_q [MP];
  logic [PW-1:0] rptr_q [MP];
  logic [CW-1:0] cnt_q  [MP];
  logic [CW-1:0] pend_q [MP];

  logic          can_issue;
  logic [MP-1:0] lane_hs;
  logic [MP-1:0] lane_nz;
  logic [MP-1:0] resp_ok;
  logic [MP-1:0] spurious;
  logic [MP-1:0] overflow;
  logic [MP-1:0] store;
  logic [MP-1:0] avail;
  logic          pop_all;
  logic [DW-1:0] head_data;

  // Request side: each lane is requested until it grants once; the wide grant
  // fires in the cycle the last outstanding lane grants.
  always_comb begin
    can_issue  = out_q < MAX_CNT;
    lane_req_o = {MP{req_i & can_issue}} & ~granted_q;
    lane_hs    = lane_req_o & lane_gnt_i;
    gnt_o      = req_i & can_issue & (&(granted_q | lane_gnt_i));
  end

  always_comb begin
    lane_add_o  = '0;
    lane_be_o   = '0;
    lane_data_o = '0;
    lane_wen_o  = {MP{wen_i}};
    for (int unsigned i = 0; i < MP; i++) begin
      lane_add_o[32*i +: 32]  = add_i + 32'(4 * i);
      lane_be_o[4*i +: 4]     = be_i[4*i +: 4];
      lane_data_o[32*i +: 32] = data_i[32*i +: 32];
    end
  end

  // Response side. An arriving response counts as available in its own cycle
  // and bypasses an empty FIFO, giving one cycle from last lane response to
  // r_valid_o. Responses on a lane with nothing pending are flagged and
  // dropped so the lane FIFOs stay aligned.
  always_comb begin
    pop_all   = 1'b1;
    head_data = '0;
    lane_nz   = '0;
    spurious  = '0;
    resp_ok   = '0;
    avail     = '0;
    overflow  = '0;
    store     = '0;
    for (int unsigned i = 0; i < MP; i++) begin
      lane_nz[i]  = cnt_q[i] != '0;
      spurious[i] = lane_r_valid_i[i] & (pend_q[i] == '0);
      resp_ok[i]  = lane_r_valid_i[i] & ~spurious[i];
      avail[i]    = lane_nz[i] | resp_ok[i];
      if (!avail[i]) pop_all = 1'b0;
      head_data[32*i +: 32] = lane_nz[i] ? fifo_q[i][rptr_q[i]] : lane_r_data_i[32*i +: 32];
    end
    for (int unsigned i = 0; i < MP; i++) begin
      overflow[i] = resp_ok[i] & (cnt_q[i] == MAX_CNT) & ~pop_all;
      store[i]    = resp_ok[i] & ~overflow[i] & ~(pop_all & ~lane_nz[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      granted_q <= '0;
      out_q     <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      granted_q <= gnt_o ? '0 : (granted_q | lane_hs);
      if (gnt_o && !r_valid_q)      out_q <= out_q + CW'(1);
      else if (!gnt_o && r_valid_q) out_q <= out_q - CW'(1);
      r_valid_q <= pop_all;
      if (pop_all) r_data_q <= head_data;
      if ((|spurious) || (|overflow)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MP; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
        pend_q[i] <= '0;
        for (int unsigned j = 0; j < MAX_OUTSTANDING; j++) fifo_q[i][j] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MP; i++) begin
        if (store[i]) begin
          fifo_q[i][wptr_q[i]] <= lane_r_data_i[32*i +: 32];
          wptr_q[i] <= (wptr_q[i] == LAST_PTR) ? '0 : wptr_q[i] + PW'(1);
        end
        if (pop_all && lane_nz[i])
          rptr_q[i] <= (rptr_q[i] == LAST_PTR) ? '0 : rptr_q[i] + PW'(1);
        case ({store[i], pop_all & lane_nz[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CW'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - CW'(1);
          default: ;
        endcase
        // Lane grants not yet answered by that lane.
        case ({lane_hs[i], resp_ok[i]})
          2'b10:   pend_q[i] <= pend_q[i] + CW'(1);
          2'b01:   pend_q[i] <= pend_q[i] - CW'(1);
          default: ;
        endcase
      end
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_data_o  = r_data_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_redmule_tcdm_splitter.sv
// Directed bench for redmule_tcdm_splitter: the bench plays the upstream
// master and the MP TCDM lanes, cycle by cycle, on the falling clock edge.
module tb_redmule_tcdm_splitter;
  localparam int unsigned DW = 288;
  localparam int unsigned MP = DW / 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic wen = 1'b0;
  logic [31:0] add = '0;
  logic [DW/8-1:0] be = '0;
  logic [DW-1:0] wdata = '0;
  logic gnt, rvalid, err;
  logic [DW-1:0] rdata;
  logic [MP-1:0] lreq, lwen;
  logic [MP-1:0] lgnt = '0;
  logic [MP-1:0] lrvalid = '0;
  logic [MP*32-1:0] ladd, ldata;
  logic [MP*32-1:0] lrdata = '0;
  logic [MP*4-1:0] lbe;

  int unsigned vecs = 0;
  int unsigned miss = 0;
  int hscnt[MP];
  logic [MP-1:0] hs_ok;
  logic [31:0] tmem[MP];
  logic [DW-1:0] exp_d;
  logic [DW/8-1:0] bev;

  always #5 clk = ~clk;

  redmule_tcdm_splitter #(.DW(DW), .MP(MP), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen),
    .be_i(be), .data_i(wdata), .r_data_o(rdata), .r_valid_o(rvalid),
    .lane_req_o(lreq), .lane_gnt_i(lgnt), .lane_add_o(ladd), .lane_wen_o(lwen),
    .lane_be_o(lbe), .lane_data_o(ldata), .lane_r_data_i(lrdata),
    .lane_r_valid_i(lrvalid), .err_o(err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] base);
    logic [DW-1:0] v = '0;
    for (int k = 0; k < MP; k++) v[32*k +: 32] = base + 32'(k);
    return v;
  endfunction

  task automatic count_hs();
    for (int k = 0; k < MP; k++) if (lreq[k] && lgnt[k]) hscnt[k]++;
  endtask

  initial begin
    // Reset values
    tick(); #1;
    chk1("rst_gnt", gnt, 1'b0);
    chk1("rst_rvalid", rvalid, 1'b0);
    chkw("rst_rdata", rdata, '0);
    chkw("rst_lreq", DW'(lreq), '0);
    chk1("rst_err", err, 1'b0);
    tick(); rst_n = 1'b1;

    // Read, all lanes grant in the request cycle, respond next cycle
    tick(); req = 1'b1; add = 32'h1C01_0000; wen = 1'b1; be = '1; lgnt = '1; #1;
    chk1("t1_gnt", gnt, 1'b1);
    chkw("t1_add8", DW'(ladd[8*32 +: 32]), DW'(32'h1C01_0020));
    chkw("t1_lreq", DW'(lreq), DW'({MP{1'b1}}));
    tick(); req = 1'b0; lgnt = '0; lrvalid = '1; lrdata = pat(32'h0); #1;
    chk1("t1_rv_early", rvalid, 1'b0);
    tick(); lrvalid = '0; #1;
    chk1("t1_rv", rvalid, 1'b1);
    chkw("t1_data", rdata, pat(32'h0));
    tick(); #1;
    chk1("t1_rv_off", rvalid, 1'b0);
    chkw("t1_hold", rdata, pat(32'h0));

    // Staggered grant: lane 3 grants three cycles after the others
    for (int k = 0; k < MP; k++) hscnt[k] = 0;
    tick(); req = 1'b1; add = 32'h1C01_0100; lgnt = '1; lgnt[3] = 1'b0; #1;
    chk1("t2_gnt_c0", gnt, 1'b0);
    count_hs();
    for (int c = 1; c < 3; c++) begin
      tick(); #1;
      chkw("t2_lreq_only3", DW'(lreq), DW'(MP'(32'h8)));
      chk1("t2_gnt_wait", gnt, 1'b0);
      count_hs();
    end
    tick(); lgnt = '1; #1;
    chk1("t2_gnt_c3", gnt, 1'b1);
    count_hs();
    tick(); req = 1'b0; lgnt = '0; #1;
    chkw("t2_lreq_idle", DW'(lreq), '0);
    for (int k = 0; k < MP; k++) hs_ok[k] = (hscnt[k] == 1);
    chkw("t2_one_grant_per_lane", DW'(hs_ok), DW'({MP{1'b1}}));

    // Staggered response: lane 5 answers four cycles after the others
    tick(); lrdata = pat(32'h200); lrvalid = '1; lrvalid[5] = 1'b0; #1;
    for (int c = 6; c < 10; c++) begin
      tick(); lrvalid = (c == 9) ? MP'(32'h20) : '0; #1;
      chk1("t3_rv_wait", rvalid, 1'b0);
    end
    tick(); lrvalid = '0; #1;
    chk1("t3_rv", rvalid, 1'b1);
    chkw("t3_data", rdata, pat(32'h200));
    tick(); #1;
    chk1("t3_rv_single", rvalid, 1'b0);

    // Back-pressure: grants stop at four outstanding
    lgnt = '1; wen = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick(); req = 1'b1; add = 32'h1C01_1000 + 32'(256 * t); #1;
      chk1("t4_gnt", gnt, 1'b1);
    end
    for (int c = 0; c < 2; c++) begin
      tick(); add = 32'h1C01_1400; #1;
      chkw("t4_lreq_blocked", DW'(lreq), '0);
      chk1("t4_gnt_blocked", gnt, 1'b0);
    end
    tick(); lrvalid = '1; lrdata = pat(32'h1000); #1;
    chk1("t4_gnt_resp_cycle", gnt, 1'b0);
    tick(); lrdata = pat(32'h1100); #1;
    chk1("t4_rv1", rvalid, 1'b1);
    chkw("t4_data1", rdata, pat(32'h1000));
    chk1("t4_gnt_still_full", gnt, 1'b0);
    tick(); lrvalid = '0; #1;
    chk1("t4_rv2", rvalid, 1'b1);
    chkw("t4_data2", rdata, pat(32'h1100));
    chk1("t4_gnt_with_rv", gnt, 1'b1);
    tick(); add = 32'h1C01_1500; #1;
    chk1("t4_gnt_slot_left", gnt, 1'b1);
    tick(); add = 32'h1C01_1600; #1;
    chk1("t4_gnt_full_again", gnt, 1'b0);
    chkw("t4_lreq_full_again", DW'(lreq), '0);
    tick(); req = 1'b0; lrvalid = '1; lrdata = pat(32'h1200); #1;
    for (int t = 3; t < 6; t++) begin
      tick(); lrdata = pat(32'h1000 + 32'(256 * t)); #1;
      chk1("t4_drain_rv", rvalid, 1'b1);
      chkw("t4_drain_data", rdata, pat(32'h1000 + 32'(256 * (t - 1))));
    end
    tick(); lrvalid = '0; #1;
    chk1("t4_drain_rv_last", rvalid, 1'b1);
    chkw("t4_drain_data_last", rdata, pat(32'h1500));
    tick(); #1;
    chk1("t4_idle", rvalid, 1'b0);

    // Partial write then read of the same address; bench memory per lane
    for (int k = 0; k < MP; k++) begin
      tmem[k] = 32'hAAAA_AAAA;
      bev[4*k +: 4] = (k % 2 == 1) ? 4'hC : 4'h3;
      exp_d[32*k +: 32] = (k % 2 == 1) ? 32'h1234_AAAA : 32'hAAAA_5678;
    end
    tick(); req = 1'b1; wen = 1'b0; add = 32'h1C01_0200; be = bev;
    wdata = {MP{32'h1234_5678}}; lgnt = '1; #1;
    chk1("t5_wgnt", gnt, 1'b1);
    chkw("t5_be_lane1", DW'(lbe[7:4]), DW'(4'hC));
    for (int k = 0; k < MP; k++)
      if (lreq[k] && lgnt[k] && !lwen[k])
        for (int b = 0; b < 4; b++)
          if (lbe[4*k + b]) tmem[k][8*b +: 8] = ldata[32*k + 8*b +: 8];
    tick(); wen = 1'b1; be = '1; lrvalid = '1; lrdata = '0; #1;
    chk1("t5_rgnt", gnt, 1'b1);
    tick(); req = 1'b0; lgnt = '0;
    for (int k = 0; k < MP; k++) lrdata[32*k +: 32] = tmem[k];
    #1;
    chk1("t5_wr_rv", rvalid, 1'b1);
    chkw("t5_wr_data", rdata, '0);
    tick(); lrvalid = '0; #1;
    chk1("t5_rd_rv", rvalid, 1'b1);
    chkw("t5_rd_merged", rdata, exp_d);
    tick(); #1;
    chk1("t5_idle", rvalid, 1'b0);

    // Stray response on lane 2, then asynchronous reset mid-transaction
    tick(); lrvalid = MP'(32'h4); #1;
    chk1("t6_err_before", err, 1'b0);
    tick(); lrvalid = '0; #1;
    chk1("t6_err_set", err, 1'b1);
    chk1("t6_no_rv", rvalid, 1'b0);
    tick(); #1;
    chk1("t6_err_sticky", err, 1'b1);
    tick(); req = 1'b1; wen = 1'b1; add = 32'h1C01_0300; lgnt = '1; #1;
    chk1("t6_gnt", gnt, 1'b1);
    tick(); req = 1'b0; lgnt = '0; #1;
    rst_n = 1'b0; #1;
    chk1("t6_rst_gnt", gnt, 1'b0);
    chk1("t6_rst_rv", rvalid, 1'b0);
    chkw("t6_rst_rdata", rdata, '0);
    chkw("t6_rst_lreq", DW'(lreq), '0);
    chk1("t6_rst_err", err, 1'b0);
    tick(); rst_n = 1'b1;
    tick(); req = 1'b1; add = 32'h1C01_0400; lgnt = '1; #1;
    chk1("t6_post_gnt", gnt, 1'b1);
    tick(); req = 1'b0; lgnt = '0; lrvalid = '1; lrdata = pat(32'h300); #1;
    tick(); lrvalid = '0; #1;
    chk1("t6_post_rv", rvalid, 1'b1);
    chkw("t6_post_data", rdata, pat(32'h300));
    chk1("t6_post_err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
